pslip_out_arbiter: RTL and testbench

- Per-output-port grant arbiter for the pSLIP crossbar scheduler. One instance per output port.
- Each cycle it can receive a priority-tagged request from each of N inputs. It finds the highest requested priority and breaks ties round-robin from a stored pointer.
- It issues a one-hot grant and holds it until the input-side accept arbiter responds. It advances its pointer only on an accepted first-iteration grant (iSLIP rule).

---
 rtl/pslip_pkg.sv | 15 +
 rtl/pslip_rr_pick.sv | 25 ++
 rtl/pslip_out_arbiter.sv | 92 +++++++++
 tb/tb_pslip_out_arbiter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/pslip_pkg.sv
// pslip_pkg: shared sizes, types and FSM states for the pSLIP output arbiter
// N        : number of input ports (requesters)
// P        : number of priority levels, value 0 of a priority field means no request
// pri_t    : priority field type
// port_idx_t : input port index type
package pslip_pkg;
    localparam int N = 16;
    localparam int P = 16;
    localparam int PW = $clog2(P);
    localparam int IW = $clog2(N);
    typedef logic [PW-1:0] pri_t;
    typedef logic [IW-1:0] port_idx_t;
    localparam pri_t PRI_NONE = '0;
    typedef enum logic {IDLE, GRANT} state_t;
endpackage

// File: rtl/pslip_rr_pick.sv
// pslip_rr_pick: combinational round-robin first-one finder
// cand   : candidate vector
// ptr    : search start position
// onehot : one-hot winner, zero when nothing found
// idx    : winner index
// found  : at least one candidate present
module pslip_rr_pick import pslip_pkg::*; (
    input  logic [N-1:0] cand,
    input  port_idx_t    ptr,
    output logic [N-1:0] onehot,
    output port_idx_t    idx,
    output logic         found
);
    logic [2*N-1:0] d;
    always_comb begin
        // lower copy loses the bits below ptr, so the lowest set bit of d is the
        // first candidate at or after ptr, wrapping into the upper copy
        d = {cand, cand & ~((N'(1) << ptr) - N'(1))};
        found = |cand;
        idx = '0;
        for (int k = 2*N-1; k >= 0; k--)
            if (d[k]) idx = port_idx_t'(k >= N ? k - N : k);
        onehot = found ? N'(1) << idx : '0;
    end
endmodule

// File: rtl/pslip_out_arbiter.sv
// pslip_out_arbiter: per-output-port priority grant arbiter with iSLIP pointer update
// clk, rst     : clock, synchronous active-high reset
// start        : begin one arbitration iteration (IDLE only)
// first_iter   : current iteration is iSLIP iteration 1, sampled with start
// pri_in       : N packed priority fields, field i at [i*PW +: PW], 0 = no request
// in_mask      : inputs already matched this slot, sampled with start
// grant        : one-hot grant, held until response
// grant_valid  : grant presented
// grant_pri    : priority of granted request
// resp_valid   : accept arbiter response strobe
// resp_accept  : grant accepted when set, qualified by resp_valid
// no_req       : one-cycle pulse when start found nothing eligible
// busy         : not IDLE
// rr_ptr       : round-robin pointer
module pslip_out_arbiter import pslip_pkg::*; (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            first_iter,
    input  logic [N*PW-1:0] pri_in,
    input  logic [N-1:0]    in_mask,
    output logic [N-1:0]    grant,
    output logic            grant_valid,
    output pri_t            grant_pri,
    input  logic            resp_valid,
    input  logic            resp_accept,
    output logic            no_req,
    output logic            busy,
    output port_idx_t       rr_ptr
);
    state_t state, state_n;
    logic [N-1:0] elig, cand, onehot;
    pri_t pmax;
    port_idx_t widx, win_q;
    logic found, fi_q;
    always_comb begin
        elig = '0;
        pmax = PRI_NONE;
        for (int i = 0; i < N; i++) begin
            elig[i] = pri_in[i*PW +: PW] != PRI_NONE && !in_mask[i];
            if (elig[i] && pri_in[i*PW +: PW] > pmax) pmax = pri_in[i*PW +: PW];
        end
    end
    always_comb begin
        cand = '0;
        for (int i = 0; i < N; i++)
            cand[i] = elig[i] && pri_in[i*PW +: PW] == pmax;
    end
    pslip_rr_pick u_pick (
        .cand   (cand),
        .ptr    (rr_ptr),
        .onehot (onehot),
        .idx    (widx),
        .found  (found)
    );
    always_comb begin
        state_n = state;
        state_n = (state == IDLE) ? ((start && found) ? GRANT : IDLE)
                                  : (resp_valid ? IDLE : GRANT);
    end
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_n;
    always_ff @(posedge clk) begin
        if (rst) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_pri   <= PRI_NONE;
            no_req      <= 1'b0;
            rr_ptr      <= '0;
            fi_q        <= 1'b0;
            win_q       <= '0;
        end else begin
            no_req <= state == IDLE && start && !found;
            if (state == IDLE && start && found) begin
                grant       <= onehot;
                grant_valid <= 1'b1;
                grant_pri   <= pmax;
                fi_q        <= first_iter;
                win_q       <= widx;
            end
            if (state == GRANT && resp_valid) begin
                grant       <= '0;
                grant_valid <= 1'b0;
                grant_pri   <= PRI_NONE;
                // only an accepted first-iteration grant moves the pointer past the winner
                if (resp_accept && fi_q)
                    rr_ptr <= (win_q == port_idx_t'(N-1)) ? '0 : win_q + 1'b1;
            end
        end
    end
    assign busy = state != IDLE;
endmodule

// File: tb/tb_pslip_out_arbiter.sv
// tb_pslip_out_arbiter: directed self-checking bench with a behavioural reference model
module tb_pslip_out_arbiter;
    import pslip_pkg::*;
    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            first_iter = 1'b0;
    logic [N*PW-1:0] pri_in = '0;
    logic [N-1:0]    in_mask = '0;
    logic [N-1:0]    grant;
    logic            grant_valid;
    pri_t            grant_pri;
    logic            resp_valid = 1'b0;
    logic            resp_accept = 1'b0;
    logic            no_req;
    logic            busy;
    port_idx_t       rr_ptr;
    int checks = 0;
    int errors = 0;
    pslip_out_arbiter dut (
        .clk(clk), .rst(rst), .start(start), .first_iter(first_iter),
        .pri_in(pri_in), .in_mask(in_mask), .grant(grant),
        .grant_valid(grant_valid), .grant_pri(grant_pri),
        .resp_valid(resp_valid), .resp_accept(resp_accept),
        .no_req(no_req), .busy(busy), .rr_ptr(rr_ptr)
    );
    always #5 clk = ~clk;
    // reference model: arbiter state kept as plain integers
    logic armed = 1'b0;
    bit   m_busy = 0, m_noreq = 0, m_fi = 0;
    int   m_ptr = 0, m_win = 0, m_pri = 0;
    logic [31:0] m_grant = '0;
    function automatic int pr(int i);
        return int'(pri_in[i*PW +: PW]);
    endfunction
    function automatic int pmax_f();
        int m = 0;
        for (int i = 0; i < N; i++)
            if (!in_mask[i] && pr(i) > m) m = pr(i);
        return m;
    endfunction
    function automatic int winner_f(int pm);
        for (int k = 0; k < N; k++)
            if (!in_mask[(m_ptr + k) % N] && pr((m_ptr + k) % N) == pm) return (m_ptr + k) % N;
        return 0;
    endfunction
    always @(posedge clk) begin
        if (rst) begin
            armed <= 1'b1;
            m_busy <= 0; m_noreq <= 0; m_fi <= 0;
            m_ptr <= 0; m_win <= 0; m_pri <= 0; m_grant <= '0;
        end else if (!m_busy) begin
            m_noreq <= 0;
            if (start) begin
                if (pmax_f() == 0) m_noreq <= 1;
                else begin
                    m_busy  <= 1;
                    m_fi    <= first_iter;
                    m_pri   <= pmax_f();
                    m_win   <= winner_f(pmax_f());
                    m_grant <= 32'd1 << winner_f(pmax_f());
                end
            end
        end else if (resp_valid) begin
            m_busy <= 0; m_pri <= 0; m_grant <= '0;
            if (resp_accept && m_fi) m_ptr <= (m_win + 1) % N;
        end
    end
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    always @(negedge clk) if (armed) begin
        chk("m_grant", 32'(grant), m_grant);
        chk("m_grant_valid", 32'(grant_valid), 32'(m_busy));
        chk("m_grant_pri", 32'(grant_pri), 32'(m_pri));
        chk("m_no_req", 32'(no_req), 32'(m_noreq));
        chk("m_busy", 32'(busy), 32'(m_busy));
        chk("m_rr_ptr", 32'(rr_ptr), 32'(m_ptr));
    end
    task automatic tick();
        @(posedge clk); #1;
    endtask
    task automatic clr();
        pri_in = '0; in_mask = '0; start = 0; resp_valid = 0; resp_accept = 0;
    endtask
    task automatic setp(int i, int v);
        pri_in[i*PW +: PW] = PW'(v);
    endtask
    task automatic go(bit fi);
        start = 1; first_iter = fi; tick(); start = 0;
    endtask
    task automatic resp(bit acc);
        resp_valid = 1; resp_accept = acc; tick(); resp_valid = 0; resp_accept = 0;
    endtask
    initial begin
        logic [N-1:0] held;
        tick(); tick();
        rst = 0;
        chk("rst_grant", 32'(grant), 0);
        chk("rst_ptr", 32'(rr_ptr), 0);
        chk("rst_busy", 32'(busy), 0);
        // highest priority wins
        setp(3, 5); setp(9, 12); go(1);
        chk("t1_grant", 32'(grant), 32'h0200);
        chk("t1_pri", 32'(grant_pri), 12);
        chk("t1_valid", 32'(grant_valid), 1);
        resp(1);
        chk("t1_ptr", 32'(rr_ptr), 10);
        chk("t1_drop", 32'(grant_valid), 0);
        // round-robin tie break with wrap
        clr(); setp(2, 8); setp(7, 8); setp(12, 8);
        go(1); chk("t2_grant12", 32'(grant), 32'h1000);
        resp(1); chk("t2_ptr13", 32'(rr_ptr), 13);
        go(1); chk("t2_grant2", 32'(grant), 32'h0004);
        resp(1); chk("t2_ptr3", 32'(rr_ptr), 3);
        // pointer wrap and non-updating cases
        clr(); setp(15, 1);
        go(1); chk("t3_grant15", 32'(grant), 32'h8000);
        resp(1); chk("t3_ptr0", 32'(rr_ptr), 0);
        clr(); setp(4, 6);
        go(0); chk("t3_grant4", 32'(grant), 32'h0010);
        resp(1); chk("t3_ptr_iter2", 32'(rr_ptr), 0);
        go(1); resp(0); chk("t3_ptr_rej", 32'(rr_ptr), 0);
        // masking and no request
        clr(); setp(9, 12); setp(1, 3); in_mask = 16'h0200;
        go(1);
        chk("t4_grant1", 32'(grant), 32'h0002);
        chk("t4_pri3", 32'(grant_pri), 3);
        resp(0);
        in_mask = 16'h0202;
        go(1);
        chk("t4_noreq", 32'(no_req), 1);
        chk("t4_busy", 32'(busy), 0);
        tick();
        chk("t4_noreq_pulse", 32'(no_req), 0);
        // hold under noise, then reset mid-grant
        clr(); setp(5, 7);
        go(1); resp(1); chk("t5_ptr6", 32'(rr_ptr), 6);
        go(1); held = grant;
        chk("t5_grant5", 32'(held), 32'h0020);
        for (int c = 0; c < 20; c++) begin
            start = c[0]; first_iter = c[1];
            pri_in = {$urandom, $urandom};
            in_mask = N'($urandom);
            tick();
            chk("t5_hold", 32'(grant), 32'(held));
        end
        clr(); setp(5, 7);
        rst = 1; tick(); rst = 0;
        chk("t5_rst_grant", 32'(grant), 0);
        chk("t5_rst_valid", 32'(grant_valid), 0);
        chk("t5_rst_ptr", 32'(rr_ptr), 0);
        chk("t5_rst_busy", 32'(busy), 0);
        // start colliding with a response is dropped
        go(1);
        start = 1; resp_valid = 1; resp_accept = 1; tick();
        start = 0; resp_valid = 0; resp_accept = 0;
        chk("t6_dropped", 32'(grant_valid), 0);
        chk("t6_ptr6", 32'(rr_ptr), 6);
        go(1);
        chk("t6_regrant", 32'(grant), 32'h0020);
        resp(1);
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
